// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving the 3-bit select of a shared 8:1 mux lane,
// with lock-based multi-cycle ownership bounded by MAX_HOLD while others wait.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HC_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] lock,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d, sel_q, sel_d, off, win;
    logic [7:0]      gnt_q, gnt_d, rot;
    logic [15:0]     dbl;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            hold_max, keep;

    always_comb begin
        // rot[i] is the request at search position i, so the lowest set bit wins
        dbl      = {req, req} >> ptr_q;
        rot      = dbl[7:0];
        off      = 3'd0;
        for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
        win      = ptr_q + off;
        hold_max = hold_q == HC_W'(MAX_HOLD - 1);
        keep     = state_q == GRANT && |(gnt_q & req & lock) && !(en && |(req & ~gnt_q) && hold_max);
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        if (keep) begin
            hold_d = hold_max ? hold_q : hold_q + 1'b1;
        end else if (en && |req) begin
            state_d = GRANT;
            gnt_d   = 8'b1 << win;
            sel_d   = win;
            hold_d  = '0;
            ptr_d   = win + 3'd1;
        end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = state_q == GRANT;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed vector table, hand sequences for hold/enable/reset corners,
// then random stimulus against a behavioural round-robin model.
module tb_mux8_rr_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst, en, gnt_valid;
    logic [7:0] req, lock, gnt;
    logic [2:0] sel;
    int checks = 0, errors = 0;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HC_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .lock(lock),
        .gnt(gnt), .sel(sel), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst, en;
        logic [7:0] req, lock, gnt;
        logic [2:0] sel;
        logic       gv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic r, input logic e, input logic [7:0] rq,
                       input logic [7:0] lk, input logic [7:0] g, input logic [2:0] s, input logic v);
        vec_t t;
        t.nm = nm; t.rst = r; t.en = e; t.req = rq; t.lock = lk; t.gnt = g; t.sel = s; t.gv = v;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic [7:0] g, input logic [2:0] s, input logic v);
        checks++;
        if (gnt !== g || sel !== s || gnt_valid !== v) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d gnt_valid=%b, want gnt=%h sel=%0d gnt_valid=%b",
                     nm, gnt, sel, gnt_valid, g, s, v);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic e, input logic [7:0] rq,
                        input logic [7:0] lk, input logic [7:0] g, input logic [2:0] s, input logic v);
        rst = r; en = e; req = rq; lock = lk;
        @(posedge clk); #1;
        check(nm, g, s, v);
    endtask

    // behavioural model: owner index (-1 when idle), priority pointer, hold count
    int m_owner, m_ptr, m_hold;
    logic [2:0] m_sel;

    task automatic model_step(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] lk);
        int w;
        bit others;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
            return;
        end
        others = m_owner >= 0 && (rq & ~(8'd1 << m_owner)) != 0;
        if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && !(e && others && m_hold == MAX_HOLD - 1)) begin
            if (m_hold < MAX_HOLD - 1) m_hold++;
        end else if (e && rq != 0) begin
            w = -1;
            for (int k = 0; k < 8; k++) if (w < 0 && rq[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
            m_owner = w; m_sel = 3'(w); m_ptr = (w + 1) % 8; m_hold = 0;
        end else begin
            m_owner = -1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'hFF; lock = 8'h00;
        // reset, then release
        add("rst0", 1, 1, 8'hFF, 8'h00, 8'h00, 0, 0);
        add("rst1", 1, 1, 8'hFF, 8'h00, 8'h00, 0, 0);
        add("rst_rel", 0, 1, 8'hFF, 8'h00, 8'h01, 0, 1);
        // rotation over 2,5,7 without gaps
        add("rot0", 0, 1, 8'hA4, 8'h00, 8'h04, 2, 1);
        add("rot1", 0, 1, 8'hA4, 8'h00, 8'h20, 5, 1);
        add("rot2", 0, 1, 8'hA4, 8'h00, 8'h80, 7, 1);
        add("rot3", 0, 1, 8'hA4, 8'h00, 8'h04, 2, 1);
        add("rot4", 0, 1, 8'hA4, 8'h00, 8'h20, 5, 1);
        add("idle_sel_hold", 0, 1, 8'h00, 8'h00, 8'h00, 5, 0);
        // forced rotation after MAX_HOLD cycles
        add("frc0", 0, 1, 8'h03, 8'h01, 8'h01, 0, 1);
        add("frc1", 0, 1, 8'h03, 8'h01, 8'h01, 0, 1);
        add("frc2", 0, 1, 8'h03, 8'h01, 8'h01, 0, 1);
        add("frc3", 0, 1, 8'h03, 8'h01, 8'h01, 0, 1);
        add("frc4", 0, 1, 8'h03, 8'h01, 8'h02, 1, 1);
        add("frc5", 0, 1, 8'h03, 8'h01, 8'h01, 0, 1);
        add("frc_idle", 0, 1, 8'h00, 8'h00, 8'h00, 0, 0);
        foreach (tbl[i]) step(tbl[i].nm, tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].lock,
                              tbl[i].gnt, tbl[i].sel, tbl[i].gv);

        // lone locked owner never forced off
        for (int i = 0; i < 20; i++) step("lone", 0, 1, 8'h10, 8'h10, 8'h10, 4, 1);
        step("lone_drop", 0, 1, 8'h00, 8'h10, 8'h00, 4, 0);

        // enable gating: owner 3 held past MAX_HOLD while en=0
        step("en_grant3", 0, 1, 8'h08, 8'h08, 8'h08, 3, 1);
        for (int i = 0; i < 6; i++) step("en_hold3", 0, 0, 8'h48, 8'h08, 8'h08, 3, 1);
        step("en_unlock", 0, 0, 8'h48, 8'h00, 8'h00, 3, 0);
        step("en_idle", 0, 0, 8'h48, 8'h00, 8'h00, 3, 0);
        step("en_grant6", 0, 1, 8'h48, 8'h00, 8'h40, 6, 1);

        // reset mid-grant restores pointer to 0
        step("mid_grant5", 0, 1, 8'h20, 8'h20, 8'h20, 5, 1);
        step("mid_keep5", 0, 1, 8'h20, 8'h20, 8'h20, 5, 1);
        step("mid_rst", 1, 1, 8'h20, 8'h20, 8'h00, 0, 0);
        step("post_rst", 0, 1, 8'hFF, 8'h00, 8'h01, 0, 1);

        // random stimulus against the model
        model_step(1, 0, 0, 0);
        step("rnd_rst", 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            logic r, e;
            logic [7:0] rq, lk;
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) != 0);
            rq = 8'($urandom) & 8'($urandom | ($urandom_range(0, 3) == 0 ? 32'hFF : 32'h0));
            lk = 8'($urandom) | 8'($urandom);
            model_step(r, e, rq, lk);
            step("rnd", r, e, rq, lk, m_owner < 0 ? 8'h00 : 8'd1 << m_owner, m_sel, m_owner >= 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter sharing one 8:1 bit-select mux lane among 8 requesters in the radix-4 datapath.
- Registers the winner's index as the 3-bit mux select and drives a one-hot grant.
- Supports lock (multi-cycle ownership) with a forced-rotation limit so no requester starves.
- Sits between requesting stages and the mux8_1 select input.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles for a locked owner while any other requester waits (legal range >=1)
HC_W, 3, width of hold counter (must satisfy 2^HC_W >= MAX_HOLD)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  permits new grants; does not revoke a current grant
req  input  8  request bit per requester i
lock  input  8  lock[i]=1: owner i wishes to keep grant beyond current cycle
gnt  output  8  registered one-hot grant, 0 when idle
sel  output  3  registered binary index of owner, feeds mux select
gnt_valid  output  1  registered; 1 when gnt nonzero

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state and outputs update on rising clk only.
- Reset: gnt=0, sel=0, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE. Reset takes effect at the next edge, including mid-grant. It wins over all other inputs.
- State: IDLE / GRANT.
- ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, ..., ptr+7, mod 8 (wraps 7->0).
- Latency: inputs sampled at edge t; resulting gnt/sel/gnt_valid are visible after edge t, i.e. 1 cycle after req.
- IDLE:
  - If en=1 and req!=0: grant first set req bit in search order to winner w. gnt=onehot(w), sel=w, gnt_valid=1, hold_cnt=0, ptr=w+1 mod 8, go to GRANT.
  - Else remain in IDLE. Outputs stay 0, except sel, which holds its last value.
- GRANT, owner o. "others" = req & ~onehot(o).
  - keep = req[o] & lock[o] & ~(en & others!=0 & hold_cnt==MAX_HOLD-1).
  - If keep: gnt/sel unchanged, hold_cnt saturating increment at MAX_HOLD-1.
  - If not keep and en=1 and req!=0: re-arbitrate the same edge. Back-to-back grant, no idle cycle. o is lowest priority because ptr=o+1. o may re-win only if no other request is pending. hold_cnt=0, ptr=winner+1.
  - Otherwise: gnt=0, gnt_valid=0, go to IDLE.
- Owner dropping req releases the grant on the next edge regardless of lock.
- lock=0 yields a 1-cycle grant.
- en=0: forced rotation is disabled, and a locked owner continues indefinitely while req&lock. No new grant is issued until en=1.
- MAX_HOLD=1: a locked owner is released every cycle whenever others are requesting.
- lock bits of non-owners are ignored.
- gnt is always one-hot or zero. sel always equals the index of the gnt bit when gnt_valid=1.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF, en=1 -> gnt=0, sel=0, gnt_valid=0. First edge after rst drops -> gnt=8'h01, sel=0.
2. Rotation: en=1, lock=0, req=8'hA4 held -> sel sequence 2,5,7,2,5,7..., one per cycle. gnt_valid stays 1 with no gaps.
3. Forced rotation (MAX_HOLD=4): req=8'h03, lock=8'h01 -> gnt=8'h01 for 4 cycles, 8'h02 for 1 cycle, repeating.
4. Lone locked owner: req=lock=8'h10 for 20 cycles -> gnt=8'h10, sel=4 for all 20 cycles. After req drops, gnt=0 and gnt_valid=0 on the next edge.
5. Enable gating: owner 3 locked, en drops while req=8'h48 -> owner 3 held past MAX_HOLD. Then lock[3]=0 with en=0 -> IDLE, gnt=0. en=1 -> grant to 6 next cycle.
6. Reset mid-grant: owner 5 active, pulse rst 1 cycle -> outputs 0 after that edge, ptr=0. Then req=8'hFF -> sel=0.
